// File: rtl/port_host.sv
// ============================================================================
// Module   : port_host
// Brief    : Host-side endpoint of the CPU nibble I/O port pair. Carries byte
//            streams both ways over toggle request/acknowledge bits and
//            presents FIFO-buffered valid/ready byte streams to the host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module port_host #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] port_out,
  output logic [31:0] port_in,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data
);

  localparam int              c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]   c_full    = (c_aw + 1)'(DEPTH);
  localparam logic [c_aw:0]   c_cnt_one = (c_aw + 1)'(1);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

  typedef enum logic [0:0] {CTRL_SYNC = 1'b0, CTRL_RUN = 1'b1} ctrl_t;
  typedef enum logic [0:0] {RX_IDLE = 1'b0, RX_PEND = 1'b1} rx_t;

  logic [31:0]   po_q;
  ctrl_t         r_ctrl;
  rx_t           r_rx_st;
  logic          r_txack;
  logic          r_rxtog;
  logic          r_rxpend;
  logic [7:0]    r_rxd;

  // from-CPU FIFO
  logic [7:0]    r_tx_mem [DEPTH];
  logic [c_aw-1:0] r_tx_wr;
  logic [c_aw-1:0] r_tx_rd;
  logic [c_aw:0] r_tx_cnt;

  // to-CPU FIFO
  logic [7:0]    r_rx_mem [DEPTH];
  logic [c_aw-1:0] r_rx_wr;
  logic [c_aw-1:0] r_rx_rd;
  logic [c_aw:0] r_rx_cnt;

  logic w_tx_push;
  logic w_tx_pop;
  logic w_rx_push;
  logic w_rx_pop;
  logic w_txfull;

  // Acceptance decisions use registered counts only, so a full FIFO refuses a
  // push even when a pop happens on the same edge.
  assign w_txfull  = (r_tx_cnt == c_full);
  assign w_tx_push = (r_ctrl == CTRL_RUN) && (po_q[8] != r_txack) && !w_txfull;
  assign m_valid   = (r_tx_cnt != '0);
  assign w_tx_pop  = m_valid && m_ready;
  assign m_data    = m_valid ? r_tx_mem[r_tx_rd] : 8'h00;

  assign s_ready   = !rst && (r_rx_cnt != c_full);
  assign w_rx_push = s_valid && s_ready;
  assign w_rx_pop  = (r_ctrl == CTRL_RUN) && (r_rx_st == RX_IDLE) && (r_rx_cnt != '0);

  assign port_in   = {18'b0, w_txfull, r_txack, 2'b00, r_rxpend, r_rxtog, r_rxd};

  // Capture the CPU output port; every protocol decision looks at this copy.
  always_ff @(posedge clk) begin
    po_q <= port_out;
  end

  // From-CPU FIFO storage: write the byte the CPU presented.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= po_q[7:0];
  end

  // From-CPU FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + c_ptr_one;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_ptr_one;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + c_cnt_one;
        2'b01:   r_tx_cnt <= r_tx_cnt - c_cnt_one;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // To-CPU FIFO storage: write the host byte.
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= s_data;
  end

  // To-CPU FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + c_ptr_one;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_ptr_one;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + c_cnt_one;
        2'b01:   r_rx_cnt <= r_rx_cnt - c_cnt_one;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // Control FSM: align toggles once after reset, then run TX ack and RX handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl   <= CTRL_SYNC;
      r_rx_st  <= RX_IDLE;
      r_txack  <= 1'b0;
      r_rxtog  <= 1'b0;
      r_rxpend <= 1'b0;
      r_rxd    <= 8'h00;
    end else begin
      case (r_ctrl)
        CTRL_SYNC: begin
          // Adopt the CPU's current levels so they are not seen as requests.
          r_txack <= po_q[8];
          r_rxtog <= po_q[12];
          r_ctrl  <= CTRL_RUN;
        end
        CTRL_RUN: begin
          if (w_tx_push) r_txack <= ~r_txack;
          case (r_rx_st)
            RX_IDLE: begin
              if (w_rx_pop) begin
                r_rxd    <= r_rx_mem[r_rx_rd];
                r_rxtog  <= ~r_rxtog;
                r_rxpend <= 1'b1;
                r_rx_st  <= RX_PEND;
              end
            end
            RX_PEND: begin
              if (po_q[12] == r_rxtog) begin
                r_rxpend <= 1'b0;
                r_rx_st  <= RX_IDLE;
              end
            end
            default: r_rx_st <= RX_IDLE;
          endcase
        end
        default: r_ctrl <= CTRL_SYNC;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/port_host.md
# port_host

Host-side endpoint of the CPU's 32-bit nibble I/O port pair: it drives the CPU's `port_in` and watches its `port_out`. It carries byte streams in both directions using a toggle request/acknowledge protocol on fixed port bits. On the host side it presents valid/ready byte streams, each direction buffered by a small FIFO. It sits in the top level beside the CPU core, on the same clock.

## Interface
- `DEPTH`, 4: entries per FIFO; power of two, at least 2.
- `clk`  in  1  system clock, shared with the CPU core.
- `rst`  in  1  reset, synchronous, active-high.
- `port_out`  in  32  the CPU's output port.
- `port_in`  out  32  drives the CPU's input port.
- `s_valid`  in  1  host has a byte for the CPU.
- `s_ready`  out  1  to-CPU FIFO can accept a byte.
- `s_data`  in  8  byte for the CPU.
- `m_valid`  out  1  a byte from the CPU is available.
- `m_ready`  in  1  host consumes the byte.
- `m_data`  out  8  byte from the CPU.

## Operation
- Port bit map, CPU to host, on `port_out`:
  - [7:0] TXD, the byte the CPU sends.
  - [8] TXREQ, toggled by the CPU once per byte.
  - [12] RXACK, toggled by the CPU once per byte taken.
- Port bit map, host to CPU, on `port_in`:
  - [7:0] RXD, the byte presented to the CPU.
  - [8] RXTOG, toggled once per byte presented.
  - [9] RXPEND.
  - [12] TXACK.
  - [13] TXFULL, set when the from-CPU FIFO is full.
  - All other `port_in` bits are held at 0.
- `port_out` is registered into `po_q` every cycle. All protocol decisions use `po_q`.
- The CPU must write TXD before it toggles TXREQ. The block relies on this ordering.
- Control FSM:
  - States are SYNC and RUN.
  - Reset enters SYNC.
  - SYNC lasts exactly one cycle:
    - TXACK <= `po_q`[8].
    - RXTOG <= `po_q`[12].
    - Then go to RUN.
  - Result: levels already present on the CPU side at reset release are not treated as requests.
- TX path (CPU to host), active in RUN:
  - When `po_q`[8] != TXACK and the from-CPU FIFO count < DEPTH:
    - Push `po_q`[7:0].
    - Toggle TXACK on the same edge.
  - If the FIFO is full, the request waits. TXACK is unchanged and TXFULL = 1.
- RX path (host to CPU) sub-FSM, with states IDLE and PEND:
  - IDLE, to-CPU FIFO non-empty, in RUN:
    - Pop the FIFO head into RXD.
    - Toggle RXTOG, set RXPEND = 1, go to PEND.
  - PEND, `po_q`[12] == RXTOG: clear RXPEND, go to IDLE.
  - RXD holds its value until the next pop.
- Host streams:
  - `s_ready` = (to-CPU count < DEPTH) and not in reset; the count is registered.
  - `m_valid` = (from-CPU count != 0).
  - `m_data` = FIFO head. It is stable while `m_valid` is high and `m_ready` is low.
- FIFO width rules:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Counts are log2(DEPTH)+1 bits.
- Simultaneous FIFO push and pop:
  - When not full, both occur and the count is unchanged.
  - When full, the pop occurs. The push is refused, because ready/acceptance is computed from the registered count.
  - On the to-CPU FIFO when empty: a same-cycle push is not visible to the RX FSM until the next cycle.

## Timing
- Reset values, in the cycle after `rst` is sampled high:
  - `port_in` = 0.
  - `s_ready` = 0.
  - `m_valid` = 0, `m_data` = 0.
  - FIFOs empty, FSM in SYNC/IDLE.
- Reset mid-transfer discards both FIFO contents and any pending RXD. SYNC then realigns the toggles.
- TXREQ toggle at `port_out` in cycle N:
  - `po_q` reflects it in N+1.
  - Push and the TXACK toggle occur at the end of N+1, so they are visible in N+2.
  - `m_valid` = 1 in N+2.
- `s_valid` & `s_ready` in cycle N, RX FSM idle:
  - Byte in FIFO at N+1.
  - RXD/RXTOG/RXPEND updated, visible at N+2.
- RXACK toggle at cycle N: RXPEND = 0 at N+2. The next byte, if queued, is presented at N+3.
- Throughput limit is one byte per CPU handshake. The block adds no extra wait beyond the above.

## Test plan
- Reset with `port_out`[8] = 1 and [12] = 1, held for 3 cycles, then released:
  - `port_in` = 0 throughout.
  - No push occurs, `m_valid` stays 0.
  - TXACK = 1 and RXTOG = 1 after SYNC.
- CPU sends 0xA5:
  - Set TXD = 0xA5, then toggle TXREQ.
  - TXACK toggles 2 cycles later.
  - `m_valid` = 1 with `m_data` = 0xA5.
  - `m_ready` = 1 pops it, and `m_valid` returns to 0.
- Host sends 0x3C, then 0xC3:
  - RXD = 0x3C, RXPEND = 1, RXTOG toggled.
  - 0xC3 is withheld until the RXACK toggle.
  - 0xC3 is presented 3 cycles after RXACK.
- Overflow, with `m_ready` = 0:
  - The CPU sends DEPTH+1 bytes 0x01..0x05.
  - TXFULL = 1 after the 4th byte. The 5th TXACK stays unchanged.
  - A single `m_ready` pulse pops 0x01. The 5th byte is then acked.
  - Order 0x01..0x05 is preserved.
- Full-FIFO simultaneous event:
  - From-CPU FIFO full, pending TXREQ, `m_ready` = 1 in the same cycle.
  - The pop occurs and the push is deferred one cycle.
  - The count goes 4 -> 3 -> 4.
- Reset asserted while RXPEND = 1 with two bytes queued:
  - After release, `port_in` = 0 and `s_ready` = 1 after SYNC.
  - The old bytes never appear on RXD.
